// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM (card, PIN lockout, op dispatch) owning the PIN/balance table.
// Define ATM_TRANSFER_EN to enable opcode 010 transfers; otherwise 010 is rejected as a bad opcode.
module atm_session_ctrl #(
  parameter int NUM_ACCTS = 4,
  parameter int BAL_W = 8,
  parameter int MAX_TRIES = 3,
  parameter int INIT_BAL = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic [3:0]       AccountID,
  input  logic             pin_valid,
  input  logic [3:0]       PIN_NUMBER,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       Operation,
  input  logic [BAL_W-1:0] amount,
  input  logic [3:0]       dest_id,
  input  logic [3:0]       new_pin,
  input  logic             Exit,
  output logic             auth_ok,
  output logic             locked,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [BAL_W-1:0] currentBalance,
  output logic [3:0]       state
);
  localparam int IW = NUM_ACCTS > 1 ? $clog2(NUM_ACCTS) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
`ifdef ATM_TRANSFER_EN
  localparam bit XFER = 1'b1;
`else
  localparam bit XFER = 1'b0;
`endif
  localparam logic [2:0] OP_DEP = 3'd0, OP_WD = 3'd1, OP_XFER = 3'd2, OP_PIN = 3'd3, OP_SHOW = 3'd4;

  typedef enum logic [3:0] {IDLE, CHECK_CARD, WAIT_PIN, LOCKOUT, MENU, READ, EXEC, WRITE, DONE} state_t;

  state_t st;
  logic [BAL_W-1:0] bal [NUM_ACCTS];
  logic [3:0] pin_tab [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_bits;
  logic [TW-1:0] tries;
  logic [IW-1:0] acct;
  logic [3:0] dst, npin;
  logic [2:0] op, ecode, ecode_q;
  logic [BAL_W-1:0] amt, src_bal, dst_bal, nsrc, new_src;
  logic [BAL_W:0] sum_src, sum_dst;
  logic bad_op, xfer;
`ifdef ATM_TRANSFER_EN
  logic [BAL_W-1:0] new_dst;
`endif

  assign state = st;
  assign op_ready = (st == MENU) && card_in && !Exit;

  // Error priority: opcode, destination, funds, overflow.
  always_comb begin
    sum_src = {1'b0, src_bal} + {1'b0, amt};
    sum_dst = {1'b0, dst_bal} + {1'b0, amt};
    xfer = op == OP_XFER;
    bad_op = op > OP_SHOW || (xfer && !XFER);
    ecode = bad_op ? 3'd7
      : xfer && (int'(dst) >= NUM_ACCTS || dst[IW-1:0] == acct) ? 3'd6
      : (op == OP_WD || xfer) && amt > src_bal ? 3'd4
      : (op == OP_DEP && sum_src[BAL_W]) || (xfer && sum_dst[BAL_W]) ? 3'd5
      : 3'd0;
    nsrc = ecode != 3'd0 ? src_bal
      : op == OP_DEP ? sum_src[BAL_W-1:0]
      : (op == OP_WD || xfer) ? src_bal - amt
      : src_bal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i] <= BAL_W'(INIT_BAL);
        pin_tab[i] <= 4'(i);
      end
      lock_bits <= '0;
      tries <= '0;
      acct <= '0;
      dst <= '0;
      npin <= '0;
      op <= '0;
      amt <= '0;
      src_bal <= '0;
      dst_bal <= '0;
      new_src <= '0;
      ecode_q <= '0;
`ifdef ATM_TRANSFER_EN
      new_dst <= '0;
`endif
      auth_ok <= 1'b0;
      locked <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
      currentBalance <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (st)
        IDLE: if (card_in) st <= CHECK_CARD;
        CHECK_CARD: begin
          acct <= AccountID[IW-1:0];
          if (int'(AccountID) >= NUM_ACCTS) begin
            err <= 1'b1;
            err_code <= 3'd1;
            st <= IDLE;
          end else if (lock_bits[AccountID[IW-1:0]]) begin
            err <= 1'b1;
            err_code <= 3'd3;
            locked <= 1'b1;
            st <= LOCKOUT;
          end else st <= WAIT_PIN;
        end
        WAIT_PIN: begin
          if (!card_in || Exit) st <= IDLE;
          else if (pin_valid) begin
            if (PIN_NUMBER == pin_tab[acct]) begin
              tries <= '0;
              auth_ok <= 1'b1;
              st <= MENU;
            end else begin
              err <= 1'b1;
              err_code <= 3'd2;
              if (int'(tries) + 1 >= MAX_TRIES) begin
                tries <= '0;
                lock_bits[acct] <= 1'b1;
                locked <= 1'b1;
                st <= LOCKOUT;
              end else tries <= tries + TW'(1);
            end
          end
        end
        LOCKOUT: if (!card_in) begin
          locked <= 1'b0;
          st <= IDLE;
        end
        MENU: begin
          if (!card_in || Exit) begin
            auth_ok <= 1'b0;
            st <= IDLE;
          end else if (op_valid) begin
            op <= Operation;
            amt <= amount;
            dst <= dest_id;
            npin <= new_pin;
            st <= READ;
          end
        end
        READ: begin
          src_bal <= bal[acct];
          dst_bal <= bal[dst[IW-1:0]];
          st <= EXEC;
        end
        EXEC: begin
          ecode_q <= ecode;
          new_src <= nsrc;
`ifdef ATM_TRANSFER_EN
          new_dst <= sum_dst[BAL_W-1:0];
`endif
          st <= WRITE;
        end
        WRITE: begin
          if (ecode_q == 3'd0) begin
            if (op == OP_DEP || op == OP_WD || op == OP_XFER) bal[acct] <= new_src;
            if (op == OP_PIN) pin_tab[acct] <= npin;
`ifdef ATM_TRANSFER_EN
            if (op == OP_XFER) bal[dst[IW-1:0]] <= new_dst;
`endif
          end
          done <= 1'b1;
          err <= ecode_q != 3'd0;
          if (ecode_q != 3'd0) err_code <= ecode_q;
          currentBalance <= new_src;
          st <= DONE;
        end
        DONE: st <= MENU;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
